// File: rtl/usb_tx_arbiter.sv
// Packet-level arbiter that shares the USB coder transmit path between N_SRC sources.
// Round-robin within priority classes, one dead cycle between packets, and a watchdog release for stalled sources.
module usb_tx_arbiter #(
   parameter int               N_SRC      = 4,
   parameter logic [N_SRC-1:0] HIPRI_MASK = N_SRC'(4'b0001),
   parameter int               TIMEOUT    = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_SRC-1:0]     tx_rdy_src,
   input  logic [8*N_SRC-1:0]   d_src,
   input  logic [N_SRC-1:0]     last_byte_src,
   output logic [N_SRC-1:0]     tx_ack_dst,
   output logic                 tx_rdy_dst,
   input  logic                 tx_ack_src,
   output logic                 last_byte_dst,
   output logic [7:0]           q,
   input  logic                 pck_sent,
   output logic [N_SRC-1:0]     gnt,
   output logic                 busy,
   output logic                 timeout
);

   localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

   state_t            r_state, w_state_nxt;
   logic [N_SRC-1:0]  r_gnt, w_gnt_nxt;
   logic [IW-1:0]     r_gnt_id, w_gnt_id_nxt;
   logic [IW-1:0]     r_rr_ptr, w_rr_nxt;
   logic [WW-1:0]     r_wdog, w_wdog_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_timeout, w_timeout_nxt;
   logic [N_SRC-1:0]  w_elig;
   logic              w_found;
   logic [IW-1:0]     w_sel;

   // High-priority requesters mask out the low class entirely
   always_comb begin
      int v_idx;
      w_elig  = ((tx_rdy_src & HIPRI_MASK) != '0) ? (tx_rdy_src & HIPRI_MASK) : tx_rdy_src;
      w_found = 1'b0;
      w_sel   = r_rr_ptr;
      for (int k = 1; k <= N_SRC; k++) begin
         v_idx = int'(r_rr_ptr) + k;
         if (v_idx >= N_SRC) v_idx = v_idx - N_SRC;
         if (!w_found && w_elig[v_idx]) begin
            w_found = 1'b1;
            w_sel   = IW'(v_idx);
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_gnt_id_nxt  = r_gnt_id;
      w_rr_nxt      = r_rr_ptr;
      w_wdog_nxt    = r_wdog;
      w_busy_nxt    = r_busy;
      w_timeout_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt  = S_XFER;
               w_gnt_nxt    = N_SRC'(1) << w_sel;
               w_gnt_id_nxt = w_sel;
               w_busy_nxt   = 1'b1;
               w_wdog_nxt   = '0;
            end
         end
         S_XFER: begin
            w_wdog_nxt = tx_ack_src ? '0 : r_wdog + 1'b1;
            // A completed packet takes precedence over a coincident watchdog expiry
            if (pck_sent) begin
               w_state_nxt = S_GAP;
               w_gnt_nxt   = '0;
               w_busy_nxt  = 1'b0;
            end else if (!tx_ack_src && r_wdog == WD_MAX) begin
               w_state_nxt   = S_GAP;
               w_gnt_nxt     = '0;
               w_busy_nxt    = 1'b0;
               w_timeout_nxt = 1'b1;
            end
         end
         S_GAP: begin
            w_rr_nxt    = r_gnt_id;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_gnt     <= '0;
         r_gnt_id  <= '0;
         r_rr_ptr  <= IW'(N_SRC - 1);
         r_wdog    <= '0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_gnt_id  <= w_gnt_id_nxt;
         r_rr_ptr  <= w_rr_nxt;
         r_wdog    <= w_wdog_nxt;
         r_busy    <= w_busy_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign gnt           = r_gnt;
   assign busy          = r_busy;
   assign timeout       = r_timeout;
   assign q             = r_busy ? d_src[{r_gnt_id, 3'b000} +: 8] : 8'h00;
   assign tx_rdy_dst    = r_busy & tx_rdy_src[r_gnt_id];
   assign last_byte_dst = r_busy & last_byte_src[r_gnt_id];
   assign tx_ack_dst    = r_busy ? (r_gnt & {N_SRC{tx_ack_src}}) : '0;

endmodule

// File: doc/usb_tx_arbiter.md
Name: usb_tx_arbiter

Overview:
- Shares the single USB coder transmit path (coder plus FTDI write side) between N_SRC packet sources, e.g. control-register reader, HSI monitor reader and future SDI/CSI dump sources.
- Grants one source at a time for a whole packet, using round-robin within priority classes.
- Forwards the granted source's data, ready and last-byte signals to the coder, and routes the coder ack back to that source only.
- Releases the grant on coder pck_sent, or on a watchdog timeout if the source stalls.
- Runs in the FTDI clock domain, upstream of usb_coder.

Parameters:
N_SRC, 4, number of requesting sources (2..8)
HIPRI_MASK, 4'b0001, bit i set = source i is in the high-priority class
TIMEOUT, 1024, max clk cycles in XFER without a coder tx_ack before forced release (>=2)

Ports:
clk  in  1  FTDI clock
rst  in  1  asynchronous reset, active-high
tx_rdy_src  in  N_SRC  per-source "byte/packet ready" request
d_src  in  8*N_SRC  per-source data byte; source i on bits [8i+7:8i]
last_byte_src  in  N_SRC  per-source last-byte-of-packet flag
tx_ack_dst  out  N_SRC  per-source byte acknowledge
tx_rdy_dst  out  1  ready to coder
tx_ack_src  in  1  byte acknowledge from coder
last_byte_dst  out  1  last-byte flag to coder
q  out  8  data byte to coder
pck_sent  in  1  coder pulse: packet fully sent
gnt  out  N_SRC  one-hot registered grant
busy  out  1  high in XFER
timeout  out  1  one-cycle pulse on watchdog release

Behaviour:
- FSM states: IDLE, XFER, GAP. All state, gnt, busy, timeout, the RR pointer and the watchdog counter are registered.
- Reset values: state=IDLE, gnt=0, busy=0, timeout=0, rr_ptr=N_SRC-1 (so source 0 is searched first), wdog=0.
- Combinational outputs are qualified by busy, so they reset to 0:
  - q = busy ? d_src[gnt_id] : 0
  - tx_rdy_dst = busy & tx_rdy_src[gnt_id]
  - last_byte_dst = busy & last_byte_src[gnt_id]
  - tx_ack_dst = busy ? (gnt & {N_SRC{tx_ack_src}}) : 0
- IDLE:
  - Eligible set = tx_rdy_src & HIPRI_MASK if that is nonzero, else tx_rdy_src.
  - Select the first eligible index searching rr_ptr+1, rr_ptr+2, ... modulo N_SRC.
  - If any source is eligible: register gnt/gnt_id, clear wdog, go to XFER on the next edge. Grant latency is 1 clk from a request sampled in IDLE.
  - With no request, stay in IDLE.
- XFER:
  - busy=1 and forwarding is active.
  - wdog increments each cycle and clears on any cycle with tx_ack_src=1.
  - pck_sent=1 -> GAP.
  - Else if wdog==TIMEOUT-1 -> timeout=1 for that cycle, then GAP.
  - If pck_sent and the timeout condition coincide, pck_sent wins and no timeout pulse is issued.
  - A source deasserting tx_rdy_src mid-packet does not release the grant; only pck_sent or timeout releases it.
  - Requests from other sources are ignored until IDLE.
- GAP:
  - One cycle with busy=0 and gnt=0 (combinational outputs are forced to 0).
  - rr_ptr <= gnt_id, then go to IDLE. This guarantees one dead cycle between packets so the coder sees tx_rdy drop.
- Fairness: within a class, a source re-requesting continuously gets at most one packet per round. Low-priority sources are served only when no high-priority source is requesting in IDLE.
- Counter width is clog2(TIMEOUT) bits, with no wrap: the counter stops in GAP and is reloaded on entering XFER.
- Asynchronous rst mid-packet returns everything to the reset values immediately. Coder-side recovery is the coder's own reset.
- pck_sent or tx_ack_src arriving outside XFER is ignored.

Test Plan:
- Single request: tx_rdy_src=4'b0100, d_src[23:16]=8'hA5 -> gnt=4'b0100 one clk later, q=8'hA5, tx_ack_src pulse appears only on tx_ack_dst[2]. On pck_sent: one GAP cycle with gnt=0, then IDLE.
- Round-robin: HIPRI_MASK=0, sources 1, 2 and 3 request continuously with 3-byte packets -> grant order 1,2,3,1,2,3. Exactly one GAP cycle between consecutive grants.
- Priority: HIPRI_MASK=4'b0001, sources 0 and 3 both request -> source 0 is granted first. Source 3 is granted after source 0's packet only if source 0 has dropped its request by IDLE; otherwise source 0 keeps winning.
- Watchdog: TIMEOUT=16, grant source 1, never assert tx_ack_src or pck_sent -> timeout pulse in the 16th XFER cycle, GAP, then IDLE. An ack at cycle 10 restarts the count, so the timeout moves to cycle 26.
- Coincidence: pck_sent in the same cycle wdog==TIMEOUT-1 -> no timeout pulse, normal GAP.
- Reset: assert rst during XFER with source 2 granted -> gnt, busy, tx_rdy_dst and q go to 0 asynchronously. After release, a request from sources 0 and 2 together grants source 0.
